mem_wb_skid_reg: RTL

//  Parametrised MEM->WB stage register. Adds a valid/ready handshake, a 1-entry skid buffer so

---
 rtl/mem_wb_skid_reg.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/mem_wb_skid_reg.sv
// -----------------------------------------------------------------------------
// mem_wb_skid_reg
//   MEM->WB pipeline stage register with a valid/ready handshake and a
//   one-entry skid buffer. ready_o is a flop, so there is no combinational
//   path from ready_i to ready_o. The block also provides:
//     - synchronous flush of both held entries
//     - zero-register write guard on reg_write_o
//     - writeback mux and a forwarding bus back to EX
//     - a wrapping retire counter
//
// Parameters
//   XLEN       data path width
//   RA_W       register address width
//   ZERO_GUARD 1: suppress register writes to x0
//              0: pass reg_write through unchanged
//   CNT_W      retire counter width
//
// Ports
//   clk_i, rst_i (sync, active-high), flush_i
//   Upstream:  valid_i, ready_o, alu_result_i, mem_data_i, rd_addr_i,
//              reg_write_i, mem_to_reg_i
//   Downstream: valid_o, ready_i, alu_result_o, mem_data_o, rd_addr_o,
//              reg_write_o, mem_to_reg_o, wb_data_o
//   Forwarding: fwd_valid_o, fwd_addr_o, fwd_data_o
//   Status:    occupancy_o (0..2), retired_o
// -----------------------------------------------------------------------------
module mem_wb_skid_reg #(
  parameter int XLEN       = 32,
  parameter int RA_W       = 5,
  parameter int ZERO_GUARD = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [XLEN-1:0]  alu_result_i,
  input  logic [XLEN-1:0]  mem_data_i,
  input  logic [RA_W-1:0]  rd_addr_i,
  input  logic             reg_write_i,
  input  logic             mem_to_reg_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [XLEN-1:0]  alu_result_o,
  output logic [XLEN-1:0]  mem_data_o,
  output logic [RA_W-1:0]  rd_addr_o,
  output logic             reg_write_o,
  output logic             mem_to_reg_o,
  output logic [XLEN-1:0]  wb_data_o,
  output logic             fwd_valid_o,
  output logic [RA_W-1:0]  fwd_addr_o,
  output logic [XLEN-1:0]  fwd_data_o,
  output logic [1:0]       occupancy_o,
  output logic [CNT_W-1:0] retired_o
);

  typedef struct packed {
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] mem;
    logic [RA_W-1:0] rd;
    logic            rw;
    logic            m2r;
  } entry_t;

  // The encoding equals the number of held entries, so it doubles as occupancy.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  entry_t           out_q, out_d;
  entry_t           skd_q, skd_d;
  entry_t           in_s;
  logic             ready_q, ready_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             accept_s;
  logic             consume_s;
  logic             valid_s;
  logic             guard_s;

  // Selects the writeback source for an entry.
  function automatic logic [XLEN-1:0] wb_sel(input entry_t e);
    return e.m2r ? e.mem : e.alu;
  endfunction

  assign in_s      = '{alu: alu_result_i, mem: mem_data_i, rd: rd_addr_i,
                       rw: reg_write_i, m2r: mem_to_reg_i};
  assign valid_s   = (state_q != ST_EMPTY);
  assign accept_s  = valid_i & ready_q;
  assign consume_s = valid_s & ready_i;

  // Next-state, payload movement and ready computation.
  always_comb begin
    state_d   = state_q;
    out_d     = out_q;
    skd_d     = skd_q;
    retired_d = consume_s ? (retired_q + CNT_W'(1'b1)) : retired_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept_s) begin
          out_d   = in_s;
          state_d = ST_ONE;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (accept_s && consume_s) begin
          out_d   = in_s;
          state_d = ST_ONE;
        end else if (accept_s) begin
          skd_d   = in_s;
          state_d = ST_FULL;
        end else if (consume_s) begin
          state_d = ST_EMPTY;
        end else begin
          state_d = ST_ONE;
        end
      end
      ST_FULL: begin
        // ready_q is low here, so the input is never taken in this state.
        if (consume_s) begin
          out_d   = skd_q;
          state_d = ST_ONE;
        end else begin
          state_d = ST_FULL;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
    // Flush drops any accept from this cycle and clears validity only;
    // payload keeps its old contents and the counter still sees the consume.
    if (flush_i) begin
      state_d = ST_EMPTY;
      out_d   = out_q;
      skd_d   = skd_q;
    end else begin
      state_d = state_d;
    end
    ready_d = (state_d != ST_FULL);
  end

  // State, payload, ready and counter registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_EMPTY;
      out_q     <= '0;
      skd_q     <= '0;
      ready_q   <= 1'b1;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      out_q     <= out_d;
      skd_q     <= skd_d;
      ready_q   <= ready_d;
      retired_q <= retired_d;
    end
  end

  assign guard_s      = (ZERO_GUARD != 0) && (out_q.rd == '0);
  assign ready_o      = ready_q;
  assign valid_o      = valid_s;
  assign alu_result_o = out_q.alu;
  assign mem_data_o   = out_q.mem;
  assign rd_addr_o    = out_q.rd;
  assign mem_to_reg_o = out_q.m2r;
  assign reg_write_o  = out_q.rw & valid_s & ~guard_s;
  assign wb_data_o    = wb_sel(out_q);
  assign fwd_valid_o  = reg_write_o;
  assign fwd_addr_o   = out_q.rd;
  assign fwd_data_o   = wb_data_o;
  assign occupancy_o  = state_q;
  assign retired_o    = retired_q;

endmodule
